// File: rtl/m_sequence_checker.sv
// Self-synchronising PRBS checker: aligns an N-bit LFSR to the received stream,
// locks after LOCK_CNT correct predictions, then counts bit errors against the flywheel.
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_SEARCH | filling the LFSR directly from the received bits
// S_VERIFY | checking predictions; LOCK_CNT clean matches enter LOCKED
// S_LOCKED | flywheel running; errors counted, error density watched
module m_sequence_checker #(
    parameter int             N        = 8,
    parameter logic [N-1:0]   POLY     = 8'b10001110,
    parameter int             LOCK_CNT = 16,
    parameter int             WIN      = 64,
    parameter int             ERR_THR  = 8,
    parameter int             CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             din_vld,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int FILL_W = $clog2(N + 1);
    localparam int OK_W   = $clog2(LOCK_CNT + 1);
    localparam int WMAX   = (WIN > ERR_THR) ? WIN : ERR_THR;
    localparam int WW     = $clog2(WMAX + 1);

    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(N - 1);
    localparam logic [OK_W-1:0]   OK_LAST   = OK_W'(LOCK_CNT - 1);
    localparam logic [WW-1:0]     WIN_LAST  = WW'(WIN - 1);
    localparam logic [WW-1:0]     ERR_LAST  = WW'(ERR_THR - 1);

    typedef enum logic [1:0] {
        S_SEARCH = 2'd0,
        S_VERIFY = 2'd1,
        S_LOCKED = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [N-1:0]       c_q, c_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic [OK_W-1:0]    ok_q, ok_d;
    logic [WW-1:0]      win_q, win_d;
    logic [WW-1:0]      werr_q, werr_d;
    logic               locked_q, locked_d;
    logic               err_pulse_q, err_pulse_d;
    logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;

    logic exp_bit;
    logic mismatch;
    logic c_zero;

    always_comb begin
        exp_bit = 1'b0;
        for (int i = 0; i < N; i++) begin
            exp_bit = exp_bit ^ (c_q[i] & POLY[N-1-i]);
        end
    end

    assign mismatch = din ^ exp_bit;
    assign c_zero   = (c_q == '0);

    always_comb begin
        state_d     = state_q;
        c_d         = c_q;
        fill_d      = fill_q;
        ok_d        = ok_q;
        win_d       = win_q;
        werr_d      = werr_q;
        err_pulse_d = 1'b0;
        err_cnt_d   = err_cnt_q;

        if (clr_cnt) begin
            err_cnt_d = '0;
        end

        if (din_vld) begin
            unique case (state_q)
                S_SEARCH: begin
                    c_d = {din, c_q[N-1:1]};
                    if (fill_q == FILL_LAST) begin
                        state_d = S_VERIFY;
                        fill_d  = '0;
                        ok_d    = '0;
                    end else begin
                        fill_d = fill_q + 1'b1;
                    end
                end
                S_VERIFY: begin
                    c_d = {din, c_q[N-1:1]};
                    // An all-zero register predicts zero forever; never count it as a match.
                    if (mismatch || c_zero) begin
                        ok_d = '0;
                    end else if (ok_q == OK_LAST) begin
                        state_d = S_LOCKED;
                        ok_d    = '0;
                        win_d   = '0;
                        werr_d  = '0;
                    end else begin
                        ok_d = ok_q + 1'b1;
                    end
                end
                S_LOCKED: begin
                    // Flywheel: shift in the prediction so a line error is counted once.
                    c_d = {exp_bit, c_q[N-1:1]};
                    if (mismatch) begin
                        err_pulse_d = 1'b1;
                        if (clr_cnt) begin
                            err_cnt_d = CNT_W'(1);
                        end else if (err_cnt_q != '1) begin
                            err_cnt_d = err_cnt_q + 1'b1;
                        end
                    end
                    if (mismatch && (werr_q == ERR_LAST)) begin
                        state_d = S_SEARCH;
                        fill_d  = '0;
                        win_d   = '0;
                        werr_d  = '0;
                    end else if (win_q == WIN_LAST) begin
                        win_d  = '0;
                        werr_d = '0;
                    end else begin
                        win_d  = win_q + 1'b1;
                        werr_d = werr_q + {{(WW-1){1'b0}}, mismatch};
                    end
                end
                default: begin
                    state_d = S_SEARCH;
                    fill_d  = '0;
                end
            endcase
        end

        locked_d = (state_d == S_LOCKED);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_SEARCH;
            c_q         <= '0;
            fill_q      <= '0;
            ok_q        <= '0;
            win_q       <= '0;
            werr_q      <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            c_q         <= c_d;
            fill_q      <= fill_d;
            ok_q        <= ok_d;
            win_q       <= win_d;
            werr_q      <= werr_d;
            locked_q    <= locked_d;
            err_pulse_q <= err_pulse_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_m_sequence_checker.sv
// Directed bench for m_sequence_checker: lock latency, error counting, loss/relock,
// sparse valid, counter clear/saturation and asynchronous reset.
module tb_m_sequence_checker;

    localparam logic [7:0] POLY = 8'b10001110;
    localparam logic [7:0] SEED = 8'b00001000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        din = 1'b0;
    logic        din_vld = 1'b0;
    logic        clr_cnt = 1'b0;
    logic        locked, err_pulse;
    logic [15:0] err_cnt;
    logic        locked_s, err_pulse_s;
    logic [3:0]  err_cnt_s;

    int checks = 0;
    int errors = 0;
    logic [7:0] g;

    always #5 clk = ~clk;

    m_sequence_checker dut (
        .clk(clk), .rst(rst), .din(din), .din_vld(din_vld), .clr_cnt(clr_cnt),
        .locked(locked), .err_pulse(err_pulse), .err_cnt(err_cnt)
    );

    m_sequence_checker #(.CNT_W(4), .ERR_THR(65)) dut_sat (
        .clk(clk), .rst(rst), .din(din), .din_vld(din_vld), .clr_cnt(clr_cnt),
        .locked(locked_s), .err_pulse(err_pulse_s), .err_cnt(err_cnt_s)
    );

    // Reference generator: output bit is the feedback bit, shifted in at the MSB.
    task automatic gen_bit(output logic b);
        logic fb;
        fb = 1'b0;
        for (int i = 0; i < 8; i++) fb = fb ^ (g[i] & POLY[7-i]);
        b = fb;
        g = {fb, g[7:1]};
    endtask

    task automatic send(input logic b, input logic v, input logic c);
        @(negedge clk);
        din = b; din_vld = v; clr_cnt = c;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; din = 1'b0; din_vld = 1'b0; clr_cnt = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        g = SEED;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked got %b want 0", locked); end
        checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL reset_err_pulse got %b want 0", err_pulse); end
        checks++; if (err_cnt !== 16'd0) begin errors++; $display("FAIL reset_err_cnt got %0d want 0", err_cnt); end
        checks++; if (err_cnt_s !== 4'd0) begin errors++; $display("FAIL reset_err_cnt_sat got %0d want 0", err_cnt_s); end
    endtask

    task automatic test_clean_lock();
        logic b;
        int first_lock = 0, drops = 0, pulses = 0;
        do_reset();
        for (int k = 1; k <= 1000; k++) begin
            gen_bit(b);
            send(b, 1'b1, 1'b0);
            if (locked && first_lock == 0) first_lock = k;
            if (!locked && first_lock != 0) drops++;
            if (err_pulse) pulses++;
        end
        checks++; if (first_lock != 24) begin errors++; $display("FAIL clean_lock_bit got %0d want 24", first_lock); end
        checks++; if (drops != 0) begin errors++; $display("FAIL clean_lock_drops got %0d want 0", drops); end
        checks++; if (pulses != 0) begin errors++; $display("FAIL clean_pulses got %0d want 0", pulses); end
        checks++; if (err_cnt !== 16'd0) begin errors++; $display("FAIL clean_err_cnt got %0d want 0", err_cnt); end
    endtask

    task automatic test_single_error();
        logic b;
        int pulses = 0, pulse_bit = 0, drops = 0;
        do_reset();
        for (int k = 1; k <= 200; k++) begin
            gen_bit(b);
            send((k == 100) ? ~b : b, 1'b1, 1'b0);
            if (err_pulse) begin pulses++; pulse_bit = k; end
            if (k >= 24 && !locked) drops++;
        end
        checks++; if (pulses != 1) begin errors++; $display("FAIL single_pulses got %0d want 1", pulses); end
        checks++; if (pulse_bit != 100) begin errors++; $display("FAIL single_pulse_bit got %0d want 100", pulse_bit); end
        checks++; if (err_cnt !== 16'd1) begin errors++; $display("FAIL single_err_cnt got %0d want 1", err_cnt); end
        checks++; if (drops != 0) begin errors++; $display("FAIL single_lock_drops got %0d want 0", drops); end
    endtask

    task automatic test_burst();
        logic b;
        logic l36 = 1'b0, l37 = 1'b1;
        int pulses = 0, relock = 0;
        do_reset();
        for (int k = 1; k <= 150; k++) begin
            gen_bit(b);
            send((k >= 30 && k <= 37) ? ~b : b, 1'b1, 1'b0);
            if (err_pulse) pulses++;
            if (k == 36) l36 = locked;
            if (k == 37) l37 = locked;
            if (k > 37 && locked && relock == 0) relock = k;
        end
        checks++; if (l36 !== 1'b1) begin errors++; $display("FAIL burst_locked_bit36 got %b want 1", l36); end
        checks++; if (l37 !== 1'b0) begin errors++; $display("FAIL burst_locked_bit37 got %b want 0", l37); end
        checks++; if (relock != 61) begin errors++; $display("FAIL burst_relock_bit got %0d want 61", relock); end
        checks++; if (pulses != 8) begin errors++; $display("FAIL burst_pulses got %0d want 8", pulses); end
        checks++; if (err_cnt !== 16'd8) begin errors++; $display("FAIL burst_err_cnt got %0d want 8", err_cnt); end
    endtask

    task automatic test_zero_stream();
        int ever = 0;
        do_reset();
        for (int k = 1; k <= 200; k++) begin
            send(1'b0, 1'b1, 1'b0);
            if (locked) ever++;
        end
        checks++; if (ever != 0) begin errors++; $display("FAIL zero_locked_cycles got %0d want 0", ever); end
        checks++; if (err_cnt !== 16'd0) begin errors++; $display("FAIL zero_err_cnt got %0d want 0", err_cnt); end
    endtask

    task automatic test_sparse_valid();
        logic b;
        int vbit = 0, first_lock = 0, pulses = 0, pulse_cyc = 0;
        do_reset();
        for (int cyc = 1; cyc <= 150; cyc++) begin
            if (cyc % 3 == 0) begin
                vbit++;
                gen_bit(b);
                send((vbit == 40) ? ~b : b, 1'b1, 1'b0);
            end else begin
                send(1'b1, 1'b0, 1'b0);
            end
            if (locked && first_lock == 0) first_lock = cyc;
            if (err_pulse) begin pulses++; pulse_cyc = cyc; end
        end
        checks++; if (first_lock != 72) begin errors++; $display("FAIL sparse_lock_clock got %0d want 72", first_lock); end
        checks++; if (pulses != 1) begin errors++; $display("FAIL sparse_pulses got %0d want 1", pulses); end
        checks++; if (pulse_cyc != 120) begin errors++; $display("FAIL sparse_pulse_clock got %0d want 120", pulse_cyc); end
        checks++; if (err_cnt !== 16'd1) begin errors++; $display("FAIL sparse_err_cnt got %0d want 1", err_cnt); end
    endtask

    task automatic test_clr_cnt();
        logic b;
        do_reset();
        for (int k = 1; k <= 50; k++) begin
            gen_bit(b);
            send((k == 35 || k == 40) ? ~b : b, 1'b1, (k == 38 || k == 40));
            if (k == 35) begin
                checks++; if (err_cnt !== 16'd1) begin errors++; $display("FAIL clr_after_err got %0d want 1", err_cnt); end
            end
            if (k == 38) begin
                checks++; if (err_cnt !== 16'd0) begin errors++; $display("FAIL clr_only got %0d want 0", err_cnt); end
            end
            if (k == 40) begin
                checks++; if (err_cnt !== 16'd1) begin errors++; $display("FAIL clr_with_err got %0d want 1", err_cnt); end
            end
        end
        clr_cnt = 1'b0;
        checks++; if (err_cnt !== 16'd1) begin errors++; $display("FAIL clr_hold got %0d want 1", err_cnt); end
    endtask

    task automatic test_saturate();
        logic b;
        int pulses = 0;
        do_reset();
        for (int k = 1; k <= 140; k++) begin
            gen_bit(b);
            send((k >= 30 && k <= 125 && (k - 30) % 5 == 0) ? ~b : b, 1'b1, 1'b0);
            if (err_pulse_s) pulses++;
        end
        checks++; if (pulses != 20) begin errors++; $display("FAIL sat_pulses got %0d want 20", pulses); end
        checks++; if (err_cnt_s !== 4'd15) begin errors++; $display("FAIL sat_err_cnt got %0d want 15", err_cnt_s); end
        checks++; if (locked_s !== 1'b1) begin errors++; $display("FAIL sat_locked got %b want 1", locked_s); end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++; if (locked_s !== 1'b0) begin errors++; $display("FAIL async_locked got %b want 0", locked_s); end
        checks++; if (err_cnt_s !== 4'd0) begin errors++; $display("FAIL async_err_cnt_sat got %0d want 0", err_cnt_s); end
        checks++; if (err_cnt !== 16'd0) begin errors++; $display("FAIL async_err_cnt got %0d want 0", err_cnt); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_clean_lock();
        test_single_error();
        test_burst();
        test_zero_stream();
        test_sparse_valid();
        test_clr_cnt();
        test_saturate();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
